// File: rtl/uart_receiver_if.sv
// Byte handoff from the UART receiver to its consumer: data/valid held until valid&ready.
interface uart_receiver_if;
  localparam int unsigned DATA_W = 8;

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronized rx, mid-bit sampling, single-entry holding register
// with valid/ready handoff, frame-error and overrun pulses.
module uart_receiver #(
  parameter logic [15:0] WTIME = 16'h28B0
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            rx,
  uart_receiver_if.master bus,
  output logic            frame_err,
  output logic            overrun
);
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] shreg;
  logic              rx_meta;
  logic              rx_s;

  logic cnt_zero_c;
  logic stop_ok_c;
  logic accept_c;

  assign cnt_zero_c = (cnt == '0);
  assign stop_ok_c  = (state == STOP) && cnt_zero_c && rx_s;
  assign accept_c   = bus.valid && bus.ready;

  // Receive FSM, synchronizer and holding register share one clocked process.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state     <= IDLE;
      cnt       <= WTIME;
      idx       <= '0;
      shreg     <= '0;
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      bus.data  <= '0;
      bus.valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= WTIME >> 1;
          end
        end
        START: begin
          // Half a bit later the line must still be low, otherwise it was a glitch.
          if (!cnt_zero_c) begin
            cnt <= cnt - CNT_W'(1);
          end else if (!rx_s) begin
            state <= DATA;
            cnt   <= WTIME;
            idx   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (!cnt_zero_c) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            shreg <= {rx_s, shreg[DATA_W-1:1]};
            cnt   <= WTIME;
            idx   <= idx + IDX_W'(1);
            if (idx == IDX_W'(DATA_W - 1)) state <= STOP;
          end
        end
        STOP: begin
          if (!cnt_zero_c) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state     <= rx_s ? IDLE : WAIT_HIGH;
            frame_err <= !rx_s;
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must rise before another start is accepted.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A delivery may coincide with the consumer taking the previous byte.
      if (stop_ok_c) begin
        if (!bus.valid || bus.ready) begin
          bus.data  <= shreg;
          bus.valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (accept_c) begin
        bus.valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter: WTIME, 16'h28B0, bit period minus one in clk cycles (bit period = WTIME+1 cycles); WTIME >= 3.
REQ-002 Port: clk  input  1  clock, all logic on rising edge.
REQ-003 Port: nrst  input  1  reset nrst, synchronous, active-high.
REQ-004 Port: rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-005 Port: data  output  8  received byte, stable while valid=1.
REQ-006 Port: valid  output  1  byte available; held until accepted.
REQ-007 Port: ready  input  1  consumer accepts byte when valid&ready at a clock edge.
REQ-008 Port: frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 Port: overrun  output  1  one-cycle pulse, completed byte dropped because the holding register was occupied.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (reset value 1); rx_s is its output; all decisions use rx_s only.
REQ-011 State machine SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH; a 16-bit down-counter; a 3-bit bit index; an 8-bit shift register.
REQ-012 IDLE: rx_s=0 -> START, counter <= WTIME>>1; else remain.
REQ-013 START: counter!=0 -> decrement; counter=0 and rx_s=0 -> DATA, counter <= WTIME, index <= 0; counter=0 and rx_s=1 -> IDLE (glitch rejected, no output).
REQ-014 DATA: counter!=0 -> decrement; counter=0 -> shift rx_s into bit 7 of shift register (shift right), counter <= WTIME, index+1; on 8th sample (index=7) -> STOP.
REQ-015 STOP: counter!=0 -> decrement; counter=0 and rx_s=1 -> deliver byte (REQ-017), -> IDLE; counter=0 and rx_s=0 -> frame_err=1 for that one cycle, byte discarded, -> WAIT_HIGH.
REQ-016 WAIT_HIGH: remain until rx_s=1, then -> IDLE; prevents a held-low line (break) from retriggering a start.
REQ-017 Delivery: if valid=0, or valid=1 and ready=1 in the same cycle, data <= shift register and valid <= 1 at that edge; otherwise data/valid unchanged and overrun=1 for one cycle.
REQ-018 valid&ready with no delivery in the same cycle SHALL clear valid at that edge; data SHALL keep its value.
REQ-019 data SHALL change only on a delivery edge; valid SHALL never drop without a handshake except by reset.
REQ-020 Sample points: start confirm (WTIME>>1)+1 cycles after the first rx_s low; each subsequent sample WTIME+1 cycles later; valid rises on the edge of the stop-bit sample.
REQ-021 frame_err and overrun SHALL never be asserted in the same cycle; neither depends on ready except as in REQ-017.
REQ-022 A new start bit SHALL be accepted in the first IDLE cycle after a good stop sample (back-to-back frames at full line rate).

Reset
REQ-023 nrst=1 at an edge SHALL set state IDLE, counter WTIME, index 0, shift register 0, synchronizer 1/1, data 0x00, valid 0, frame_err 0, overrun 0.
REQ-024 Reset mid-frame SHALL abandon the frame with no output; the first rx_s falling edge after nrst deasserts starts a new frame.

Verification (WTIME=15, bit period 16 cycles, ready=1 unless stated)
REQ-025 Frame 0xA5, stop=1 -> valid=1, data=0xA5, frame_err=0, overrun=0; valid drops the next edge.
REQ-026 rx low for 4 cycles then high -> no valid, no frame_err; state returns IDLE; a following frame 0x3C is received correctly.
REQ-027 Frame 0x3C with stop=0, rx held low 60 cycles then high -> one frame_err pulse, valid stays 0, no second start until rx rises then falls again.
REQ-028 ready=0, frames 0x11 then 0x22 -> valid=1, data=0x11, one overrun pulse at the 0x22 stop sample; then ready=1 -> 0x11 accepted, valid=0.
REQ-029 Back-to-back frames 0x01, 0xFE with no idle gap, ready asserted on the cycle of the second delivery -> both bytes delivered in order, valid stays 1 across the second delivery edge, no overrun.
REQ-030 nrst pulsed during DATA bit 4 of 0x77 -> all outputs at reset values; next clean frame 0x5A -> data=0x5A, valid=1.
